network_controller: RTL

NETWORK_CONTROLLER -- requirements
Module: network_controller

---
 rtl/network_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/network_controller.sv
// Sequencer for a chain of dense layers: clears all layers, then launches and
// waits on each layer in turn, with a per-layer timeout and a pass cycle counter.
module network_controller #(
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_outputs_ready,
    output logic [NUM_LAYERS-1:0] layer_inputs_ready,
    output logic                  clear_layers,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LW-1:0]         current_layer,
    output logic [31:0]           cycle_count
);

    localparam int unsigned    TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [LW-1:0]  LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         layer_q, layer_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [31:0]           count_q, count_d;
    logic [NUM_LAYERS-1:0] launch_q, launch_d;
    logic                  clear_q, clear_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [NUM_LAYERS-1:0] layer_sel;
    logic                  layer_ready;

    // Only the completion flag of the layer currently being waited on matters.
    assign layer_sel   = NUM_LAYERS'(1) << layer_q;
    assign layer_ready = |(layer_outputs_ready & layer_sel);

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        timer_d = timer_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                layer_d = '0;
                count_d = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (layer_ready) begin
                    if (layer_q == LAST_LAYER) begin
                        state_d = S_DONE;
                    end else begin
                        layer_d = layer_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (start) state_d = S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q == S_ISSUE || state_q == S_WAIT) && count_q != '1) begin
            count_d = count_q + 1'b1;
        end

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        clear_d  = (state_d == S_CLEAR);
        busy_d   = (state_d == S_CLEAR) || (state_d == S_ISSUE) || (state_d == S_WAIT);
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERROR);
        launch_d = '0;
        if (state_d == S_ISSUE) begin
            launch_d = NUM_LAYERS'(1) << layer_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            layer_q  <= '0;
            timer_q  <= '0;
            count_q  <= '0;
            launch_q <= '0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            launch_q <= launch_d;
            clear_q  <= clear_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign layer_inputs_ready = launch_q;
    assign clear_layers       = clear_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign current_layer      = layer_q;
    assign cycle_count        = count_q;

endmodule
